dispatch_buffer: RTL and testbench

//  Parametrised dispatch stage: DEPTH-entry FIFO of decoded micro-ops between decoder and ROB/RS/LSB.

---
 rtl/dispatch_buffer.sv | 189 ++++++++++++++++++
 tb/tb_dispatch_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_buffer.sv
// Dispatch stage: DEPTH-entry micro-op FIFO that resolves operands at the head and issues
// one micro-op per cycle to ROB + RS/LSB. Optional CDB bypass: define DISPATCH_CDB_BYPASS_EN.
module dispatch_buffer #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter int REG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [OP_W-1:0]  in_optype,
  input  logic             in_is_ls,
  input  logic             in_is_jump,
  input  logic             in_pred_jump,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             rob_full,
  input  logic             lsb_full,
  input  logic             rs_full,
  input  logic [ROB_W-1:0] rob_id,
  output logic [REG_W-1:0] rs1_idx,
  output logic [REG_W-1:0] rs2_idx,
  input  logic [ROB_W-1:0] rf_qi,
  input  logic [ROB_W-1:0] rf_qj,
  input  logic [XLEN-1:0]  rf_vi,
  input  logic [XLEN-1:0]  rf_vj,
  output logic [ROB_W-1:0] rob_qi,
  output logic [ROB_W-1:0] rob_qj,
  input  logic             rob_qi_rdy,
  input  logic             rob_qj_rdy,
  input  logic [XLEN-1:0]  rob_vi,
  input  logic [XLEN-1:0]  rob_vj,
`ifdef DISPATCH_CDB_BYPASS_EN
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
`endif
  output logic             rob_push,
  output logic             rename_en,
  output logic             rs_push,
  output logic             lsb_push,
  output logic [ROB_W-1:0] iss_tag,
  output logic [XLEN-1:0]  iss_pc,
  output logic [XLEN-1:0]  iss_imm,
  output logic [XLEN-1:0]  iss_vi,
  output logic [XLEN-1:0]  iss_vj,
  output logic [OP_W-1:0]  iss_optype,
  output logic [REG_W-1:0] iss_rd,
  output logic [ROB_W-1:0] iss_qi,
  output logic [ROB_W-1:0] iss_qj,
  output logic             iss_is_jump,
  output logic             iss_pred_jump
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  optype;
    logic             is_ls;
    logic             is_jump;
    logic             pred_jump;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
  } uop_t;

  typedef struct packed {
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0]  v;
  } opnd_t;

  uop_t             mem [DEPTH];
  uop_t             head_uop;
  uop_t             in_uop;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, go;
  opnd_t            op1, op2;

  // Register file first, then ROB result, then (optionally) the CDB broadcast this cycle.
  function automatic opnd_t resolve(input logic [ROB_W-1:0] q, input logic [XLEN-1:0] rf_v,
                                    input logic rob_rdy, input logic [XLEN-1:0] rob_v);
    opnd_t r;
    if (q == '0) begin
      r.q = '0;
      r.v = rf_v;
    end else if (rob_rdy) begin
      r.q = '0;
      r.v = rob_v;
`ifdef DISPATCH_CDB_BYPASS_EN
    end else if (cdb_valid && cdb_tag == q) begin
      r.q = '0;
      r.v = cdb_value;
`endif
    end else begin
      r.q = q;
      r.v = '0;
    end
    return r;
  endfunction

  assign in_uop   = '{pc: in_pc, optype: in_optype, is_ls: in_is_ls, is_jump: in_is_jump,
                      pred_jump: in_pred_jump, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
  assign head_uop = mem[head];
  assign in_ready = (count != CNT_W'(DEPTH));
  assign rs1_idx  = head_uop.rs1;
  assign rs2_idx  = head_uop.rs2;
  assign rob_qi   = rf_qi;
  assign rob_qj   = rf_qj;

  assign push = in_valid && in_ready && rdy && !flush;
  assign go   = rdy && !flush && (count != '0) && !rob_full &&
                (head_uop.is_ls ? !lsb_full : !rs_full);

  always_comb begin
    op1 = resolve(rf_qi, rf_vi, rob_qi_rdy, rob_vi);
    op2 = resolve(rf_qj, rf_vj, rob_qj_rdy, rob_vj);
  end

  // NOTE: payload storage carries no reset; count/head/tail alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_uop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rob_push      <= 1'b0;
      rename_en     <= 1'b0;
      rs_push       <= 1'b0;
      lsb_push      <= 1'b0;
      iss_tag       <= '0;
      iss_pc        <= '0;
      iss_imm       <= '0;
      iss_vi        <= '0;
      iss_vj        <= '0;
      iss_optype    <= '0;
      iss_rd        <= '0;
      iss_qi        <= '0;
      iss_qj        <= '0;
      iss_is_jump   <= 1'b0;
      iss_pred_jump <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rob_push  <= 1'b0;
      rename_en <= 1'b0;
      rs_push   <= 1'b0;
      lsb_push  <= 1'b0;
    end else if (rdy) begin
      if (push) tail <= tail + 1'b1;
      if (go) head <= head + 1'b1;
      count     <= count + CNT_W'(push) - CNT_W'(go);
      rob_push  <= go;
      rename_en <= go;
      rs_push   <= go && !head_uop.is_ls;
      lsb_push  <= go && head_uop.is_ls;
      // Payload is only refreshed on issue so consumers see stable values between strobes.
      if (go) begin
        iss_tag       <= rob_id;
        iss_pc        <= head_uop.pc;
        iss_imm       <= head_uop.imm;
        iss_optype    <= head_uop.optype;
        iss_rd        <= head_uop.rd;
        iss_is_jump   <= head_uop.is_jump;
        iss_pred_jump <= head_uop.pred_jump;
        iss_qi        <= op1.q;
        iss_vi        <= op1.v;
        iss_qj        <= op2.q;
        iss_vj        <= op2.v;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed self-checking bench for dispatch_buffer (DEPTH=4); CDB cases when DISPATCH_CDB_BYPASS_EN is defined.
module tb_dispatch_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_imm;
  logic [5:0]  in_optype;
  logic        in_is_ls, in_is_jump, in_pred_jump;
  logic [4:0]  in_rd, in_rs1, in_rs2, rs1_idx, rs2_idx;
  logic        rob_full, lsb_full, rs_full;
  logic [3:0]  rob_id, rf_qi, rf_qj, rob_qi, rob_qj;
  logic [31:0] rf_vi, rf_vj, rob_vi, rob_vj;
  logic        rob_qi_rdy, rob_qj_rdy;
  logic        rob_push, rename_en, rs_push, lsb_push;
  logic [3:0]  iss_tag, iss_qi, iss_qj;
  logic [31:0] iss_pc, iss_imm, iss_vi, iss_vj;
  logic [5:0]  iss_optype;
  logic [4:0]  iss_rd;
  logic        iss_is_jump, iss_pred_jump;
`ifdef DISPATCH_CDB_BYPASS_EN
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
`endif

  int checks = 0;
  int failures = 0;

  dispatch_buffer #(.XLEN(32), .ROB_W(4), .OP_W(6), .REG_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_optype(in_optype),
    .in_is_ls(in_is_ls), .in_is_jump(in_is_jump), .in_pred_jump(in_pred_jump),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .rob_full(rob_full), .lsb_full(lsb_full), .rs_full(rs_full), .rob_id(rob_id),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rf_qi(rf_qi), .rf_qj(rf_qj), .rf_vi(rf_vi), .rf_vj(rf_vj),
    .rob_qi(rob_qi), .rob_qj(rob_qj), .rob_qi_rdy(rob_qi_rdy), .rob_qj_rdy(rob_qj_rdy),
    .rob_vi(rob_vi), .rob_vj(rob_vj),
`ifdef DISPATCH_CDB_BYPASS_EN
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
`endif
    .rob_push(rob_push), .rename_en(rename_en), .rs_push(rs_push), .lsb_push(lsb_push),
    .iss_tag(iss_tag), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_vi(iss_vi), .iss_vj(iss_vj),
    .iss_optype(iss_optype), .iss_rd(iss_rd), .iss_qi(iss_qi), .iss_qj(iss_qj),
    .iss_is_jump(iss_is_jump), .iss_pred_jump(iss_pred_jump)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_imm = '0; in_optype = '0; in_is_ls = 1'b0; in_is_jump = 1'b0;
    in_pred_jump = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    rob_full = 1'b0; lsb_full = 1'b0; rs_full = 1'b0; rob_id = '0;
    rf_qi = '0; rf_qj = '0; rf_vi = '0; rf_vj = '0;
    rob_qi_rdy = 1'b0; rob_qj_rdy = 1'b0; rob_vi = '0; rob_vj = '0;
`ifdef DISPATCH_CDB_BYPASS_EN
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
`endif

    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_rob_push", rob_push, 0);
    check("rst_rs_push", rs_push, 0);
    check("rst_lsb_push", lsb_push, 0);
    check("rst_iss_pc", iss_pc, 0);
    check("rst_iss_tag", iss_tag, 0);
    rst = 1'b0;

    // ALU op, rs1=x1 ready in regfile with value 5
    rob_id = 4'd1; rf_vi = 32'd5; rf_vj = 32'd6;
    in_valid = 1'b1; in_pc = 32'h100; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3;
    in_imm = 32'd7; in_optype = 6'h0d; in_is_ls = 1'b0; in_is_jump = 1'b1; in_pred_jump = 1'b1;
    step();
    in_valid = 1'b0;
    check("alu_rs1_idx", rs1_idx, 1);
    check("alu_no_issue_yet", rob_push, 0);
    step();
    check("alu_rs_push", rs_push, 1);
    check("alu_rob_push", rob_push, 1);
    check("alu_rename_en", rename_en, 1);
    check("alu_lsb_push", lsb_push, 0);
    check("alu_iss_qi", iss_qi, 0);
    check("alu_iss_vi", iss_vi, 5);
    check("alu_iss_vj", iss_vj, 6);
    check("alu_iss_tag", iss_tag, 1);
    check("alu_iss_pc", iss_pc, 32'h100);
    check("alu_iss_rd", iss_rd, 3);
    check("alu_iss_imm", iss_imm, 7);
    check("alu_iss_optype", iss_optype, 6'h0d);
    check("alu_iss_jump", {iss_is_jump, iss_pred_jump}, 2'b11);
    step();
    check("alu_strobe_drop", rs_push, 0);
    check("alu_payload_hold", iss_pc, 32'h100);
    in_is_jump = 1'b0; in_pred_jump = 1'b0;

    // Load with rs2 renamed to ROB tag 3, not yet ready
    rob_id = 4'd2; rf_qj = 4'd3; rob_qj_rdy = 1'b0; rob_vj = 32'd9;
    in_valid = 1'b1; in_pc = 32'h200; in_is_ls = 1'b1; in_rs2 = 5'd4;
    step();
    in_valid = 1'b0;
    check("ld_rob_qj", rob_qj, 3);
    step();
    check("ld_lsb_push", lsb_push, 1);
    check("ld_rs_push", rs_push, 0);
    check("ld_iss_qj", iss_qj, 3);
    check("ld_iss_vj", iss_vj, 0);
    check("ld_iss_tag", iss_tag, 2);

    // Same load, ROB now holds the result 9
    rob_id = 4'd3; rob_qj_rdy = 1'b1;
    in_valid = 1'b1; in_pc = 32'h204;
    step();
    in_valid = 1'b0;
    step();
    check("ld2_lsb_push", lsb_push, 1);
    check("ld2_iss_qj", iss_qj, 0);
    check("ld2_iss_vj", iss_vj, 9);
    check("ld2_iss_pc", iss_pc, 32'h204);
    rf_qj = '0; rob_qj_rdy = 1'b0;

    // rs_full: five pushes into a four-entry buffer
    rs_full = 1'b1; in_is_ls = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_no_issue", rob_push, 0);
    rs_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rob_id = 4'(4 + k);
      step();
      check("drain_rs_push", rs_push, 1);
      check("drain_iss_pc", iss_pc, 32'h300 + 32'(4 * k));
      check("drain_iss_tag", iss_tag, 32'(4 + k));
    end
    check("drain_in_ready", in_ready, 1);
    step();
    check("drain_fifth_dropped", rob_push, 0);

    // Head is a load blocked by lsb_full; the ALU op behind it must wait
    lsb_full = 1'b1;
    in_valid = 1'b1; in_pc = 32'h400; in_is_ls = 1'b1;
    step();
    in_pc = 32'h404; in_is_ls = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("lsbf_rob_push", rob_push, 0);
    check("lsbf_rs_push", rs_push, 0);
    check("lsbf_lsb_push", lsb_push, 0);
    lsb_full = 1'b0; rob_id = 4'd8;
    step();
    check("lsbf_rel_lsb_push", lsb_push, 1);
    check("lsbf_rel_pc", iss_pc, 32'h400);
    check("lsbf_rel_tag", iss_tag, 8);
    rob_id = 4'd9;
    step();
    check("lsbf_alu_rs_push", rs_push, 1);
    check("lsbf_alu_lsb_push", lsb_push, 0);
    check("lsbf_alu_pc", iss_pc, 32'h404);

    // Flush with three entries buffered and an issue strobe live
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0; rs_full = 1'b0; rob_id = 4'd10;
    step();
    check("fl_pre_rs_push", rs_push, 1);
    check("fl_pre_pc", iss_pc, 32'h500);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5f0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_rs_push", rs_push, 0);
    check("fl_rob_push", rob_push, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_payload_hold", iss_pc, 32'h500);
    step(); step();
    check("fl_no_issue", rob_push, 0);

    // rdy low freezes strobes and ignores inputs
    rob_id = 4'd11;
    in_valid = 1'b1; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    step();
    check("rdy_issue", rs_push, 1);
    rdy = 1'b0; in_valid = 1'b1; in_pc = 32'h6f0;
    step();
    check("rdy_hold_strobe", rs_push, 1);
    check("rdy_hold_tag", iss_tag, 11);
    in_valid = 1'b0; rdy = 1'b1;
    step();
    check("rdy_resume_drop", rs_push, 0);
    step();
    check("rdy_nothing_enq", rob_push, 0);

    // Unresolved source with no bypass available
    rf_qi = 4'd2; rob_qi_rdy = 1'b0; rf_vi = 32'd5; rob_id = 4'd12;
    in_valid = 1'b1; in_pc = 32'h700;
    step();
    in_valid = 1'b0;
    step();
    check("unres_iss_qi", iss_qi, 2);
    check("unres_iss_vi", iss_vi, 0);

`ifdef DISPATCH_CDB_BYPASS_EN
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h77; rob_id = 4'd13;
    in_valid = 1'b1; in_pc = 32'h704;
    step();
    in_valid = 1'b0;
    step();
    check("cdb_iss_qi", iss_qi, 0);
    check("cdb_iss_vi", iss_vi, 32'h77);
    cdb_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
